// File: rtl/bfsk_pkg.sv
// Shared constants for the BFSK tone generators and the demodulator:
// mid-scale code, default tone periods, decision threshold and FSM encoding.
package bfsk_pkg;

  localparam logic [15:0] MIDSCALE         = 16'd32768;
  localparam int          TONE_PERIOD_FAST = 128;
  localparam int          TONE_PERIOD_SLOW = 256;
  localparam int          TONE_THRESH      = 192;

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/bfsk_demodulator_if.sv
// Sample input and decision/status outputs of the BFSK demodulator.
// master: the sample source and the consumer of the decisions. slave: the demodulator.
interface bfsk_demodulator_if #(
  parameter int CNT_W = 10
);
  logic [15:0]      signal;
  logic             bit_out;
  logic             bit_valid;
  logic [CNT_W-1:0] period;
  logic             carrier_lock;
  logic             glitch;
  logic             timeout;

  modport master (
    output signal,
    input  bit_out, bit_valid, period, carrier_lock, glitch, timeout
  );

  modport slave (
    input  signal,
    output bit_out, bit_valid, period, carrier_lock, glitch, timeout
  );
endinterface

// File: rtl/hyst_crossing_detector.sv
// Registers the incoming sample and flags rising mid-scale crossings.
// A crossing only counts after the sample has first dipped below the lower
// hysteresis bound, so noise around mid-scale cannot produce extra edges.
module hyst_crossing_detector
  import bfsk_pkg::*;
#(
  parameter int HYST = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] sample_i,
  output logic        crossing_o
);

  localparam logic [15:0] LO_BOUND = 16'(int'(MIDSCALE) - HYST);
  localparam logic [15:0] HI_BOUND = 16'(int'(MIDSCALE) + HYST);

  logic [15:0] sample_q;
  logic        armed_q;
  logic        armed_d;

  // Crossing fires from the armed state; it disarms, taking priority over re-arming.
  always_comb begin
    crossing_o = armed_q && (sample_q >= HI_BOUND);
    armed_d    = armed_q;
    if (crossing_o) begin
      armed_d = 1'b0;
    end else if (sample_q <= LO_BOUND) begin
      armed_d = 1'b1;
    end
  end

  // Input sample register and arming flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      sample_q <= sample_i;
      armed_q  <= armed_d;
    end
  end

endmodule

// File: rtl/bfsk_demodulator.sv
// BFSK demodulator: measures the period between hysteresis-qualified rising
// mid-scale crossings and decodes one bit per completed period (short period
// = 1, long period = 1'b0). Also reports lock, glitch and loss-of-carrier.
module bfsk_demodulator
  import bfsk_pkg::*;
#(
  parameter int HYST       = 1024,
  parameter int THRESH     = TONE_THRESH,
  parameter int MIN_PERIOD = 64,
  parameter int MAX_PERIOD = 512,
  parameter int CNT_W      = 10
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  bfsk_demodulator_if.slave  bus
);

  logic             crossing;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             lock_q, lock_d;
  logic             glitch_q, glitch_d;
  logic             timeout_q, timeout_d;

  hyst_crossing_detector #(
    .HYST (HYST)
  ) u_det (
    .clk_i      (CLOCK_50),
    .rst_ni     (RESET_N),
    .sample_i   (bus.signal),
    .crossing_o (crossing)
  );

  // Next-state and output decisions; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    lock_d      = lock_q;
    glitch_d    = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        cnt_d = '0;
        if (crossing) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (crossing) begin
          // A crossing exactly at MAX_PERIOD still counts as a valid period.
          if (cnt_q >= CNT_W'(MIN_PERIOD)) begin
            period_d    = cnt_q;
            bit_out_d   = (cnt_q < CNT_W'(THRESH));
            bit_valid_d = 1'b1;
            lock_d      = 1'b1;
          end else begin
            glitch_d = 1'b1;
            lock_d   = 1'b0;
          end
          cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(MAX_PERIOD)) begin
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          cnt_d     = '0;
          state_d   = SEARCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = SEARCH;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, period counter and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= SEARCH;
      cnt_q       <= '0;
      period_q    <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      lock_q      <= 1'b0;
      glitch_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      lock_q      <= lock_d;
      glitch_q    <= glitch_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.bit_out      = bit_out_q;
  assign bus.bit_valid    = bit_valid_q;
  assign bus.period       = period_q;
  assign bus.carrier_lock = lock_q;
  assign bus.glitch       = glitch_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_bfsk_demodulator.sv
// Directed bench for bfsk_demodulator: sine tones at both rates, tone switch,
// loss of carrier, sub-minimum periods, in-hysteresis signal and mid-run reset.
module tb_bfsk_demodulator;
  import bfsk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  bfsk_demodulator_if #(.CNT_W(10)) bus ();

  bfsk_demodulator #(
    .HYST(1024), .THRESH(192), .MIN_PERIOD(64), .MAX_PERIOD(512), .CNT_W(10)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // stimulus state
  int  mode = 0;      // 0 sine, 1 constant mid-scale, 2 square 40-cycle
  int  phase = 0;
  int  step = 2;
  real amp = 30000.0;
  int  sq_cnt = 0;

  // observation state
  int cyc = 0;
  int n_bv, n_gl, n_to, n_bit0, n_bit1, n_lock_low_bv, n_lock_bad, n_excl, n_lock_high;
  int per_min, per_max, ivl_min, ivl_max, gl_ivl_min, gl_ivl_max;
  int last_per, last_bit;
  int prev_bv_cyc = -1, prev_gl_cyc = -1, last_bv_cyc = -1, last_to_cyc = -1;
  logic prev_lock = 1'b0;

  function automatic logic [15:0] sine_val(input int p, input real a);
    real v;
    v = 32768.0 + a * $sin(6.283185307179586 * real'(p) / 256.0);
    return 16'($rtoi(v));
  endfunction

  task automatic clear_stats();
    n_bv = 0; n_gl = 0; n_to = 0; n_bit0 = 0; n_bit1 = 0;
    n_lock_low_bv = 0; n_lock_bad = 0; n_excl = 0; n_lock_high = 0;
    per_min = 1 << 30; per_max = -1; ivl_min = 1 << 30; ivl_max = -1;
    gl_ivl_min = 1 << 30; gl_ivl_max = -1; last_per = -1; last_bit = -1;
    prev_bv_cyc = -1; prev_gl_cyc = -1;
    prev_lock = bus.carrier_lock;
  endtask

  task automatic next_input();
    phase = (phase + step) & 255;
    sq_cnt = (sq_cnt + 1) % 40;
    case (mode)
      0: bus.signal = sine_val(phase, amp);
      1: bus.signal = 16'd32768;
      default: bus.signal = (sq_cnt < 20) ? 16'd0 : 16'd65535;
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if ((int'(bus.bit_valid) + int'(bus.glitch) + int'(bus.timeout)) > 1) n_excl++;
      if (bus.carrier_lock !== prev_lock && !(bus.bit_valid || bus.glitch || bus.timeout))
        n_lock_bad++;
      if (bus.carrier_lock) n_lock_high++;
      prev_lock = bus.carrier_lock;
      if (bus.bit_valid) begin
        n_bv++;
        if (bus.bit_out) n_bit1++; else n_bit0++;
        if (!bus.carrier_lock) n_lock_low_bv++;
        last_per = int'(bus.period);
        last_bit = int'(bus.bit_out);
        if (last_per < per_min) per_min = last_per;
        if (last_per > per_max) per_max = last_per;
        if (prev_bv_cyc >= 0) begin
          if (cyc - prev_bv_cyc < ivl_min) ivl_min = cyc - prev_bv_cyc;
          if (cyc - prev_bv_cyc > ivl_max) ivl_max = cyc - prev_bv_cyc;
        end
        prev_bv_cyc = cyc;
        last_bv_cyc = cyc;
      end
      if (bus.glitch) begin
        n_gl++;
        if (prev_gl_cyc >= 0) begin
          if (cyc - prev_gl_cyc < gl_ivl_min) gl_ivl_min = cyc - prev_gl_cyc;
          if (cyc - prev_gl_cyc > gl_ivl_max) gl_ivl_max = cyc - prev_gl_cyc;
        end
        prev_gl_cyc = cyc;
      end
      if (bus.timeout) begin
        n_to++;
        last_to_cyc = cyc;
      end
      next_input();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    phase = 0; sq_cnt = 0;
    bus.signal = 16'd32768;
    repeat (3) @(posedge clk);
    #5;
    rst_n = 1'b1;
    clear_stats();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.signal = 16'd32768;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.bit_out, bus.bit_valid, bus.period, bus.carrier_lock, bus.glitch, bus.timeout} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b exp=0",
               {bus.bit_out, bus.bit_valid, bus.period, bus.carrier_lock, bus.glitch, bus.timeout});
    end
    tests_run++;
    if (dut.state_q !== SEARCH) begin
      tests_failed++;
      $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, SEARCH);
    end
    do_reset();
  endtask

  task automatic test_fast_tone();
    mode = 0; step = 2; amp = 30000.0;
    clear_stats();
    run(1100);
    tests_run++;
    if (n_bv < 7 || n_bv > 8) begin
      tests_failed++; $display("FAIL fast_bv_count got=%0d exp=7..8", n_bv);
    end
    tests_run++;
    if (per_min != 128 || per_max != 128) begin
      tests_failed++; $display("FAIL fast_period got=%0d..%0d exp=128", per_min, per_max);
    end
    tests_run++;
    if (ivl_min != 128 || ivl_max != 128) begin
      tests_failed++; $display("FAIL fast_interval got=%0d..%0d exp=128", ivl_min, ivl_max);
    end
    tests_run++;
    if (n_bit0 != 0 || n_bit1 != n_bv) begin
      tests_failed++; $display("FAIL fast_bits got ones=%0d zeros=%0d exp all ones", n_bit1, n_bit0);
    end
    tests_run++;
    if (n_lock_low_bv != 0 || n_lock_bad != 0 || n_excl != 0 || n_gl != 0 || n_to != 0) begin
      tests_failed++;
      $display("FAIL fast_status got lowlock=%0d lockbad=%0d excl=%0d gl=%0d to=%0d exp=0",
               n_lock_low_bv, n_lock_bad, n_excl, n_gl, n_to);
    end
  endtask

  task automatic test_tone_switch();
    int guard;
    guard = 0;
    while (phase != 0 && guard < 256) begin
      run(1);
      guard++;
    end
    step = 1;
    clear_stats();
    run(1000);
    tests_run++;
    if (last_per != 256 || last_bit != 0) begin
      tests_failed++; $display("FAIL switch_last got period=%0d bit=%0d exp period=256 bit=0", last_per, last_bit);
    end
    tests_run++;
    if (n_bit0 < 2 || n_gl != 0 || n_to != 0 || n_lock_bad != 0) begin
      tests_failed++;
      $display("FAIL switch_status got zeros=%0d gl=%0d to=%0d lockbad=%0d exp zeros>=2 others 0",
               n_bit0, n_gl, n_to, n_lock_bad);
    end
    tests_run++;
    if (ivl_max != 256) begin
      tests_failed++; $display("FAIL switch_interval got=%0d exp=256", ivl_max);
    end
  endtask

  task automatic test_timeout();
    mode = 1;
    clear_stats();
    run(600);
    tests_run++;
    if (n_to != 1 || (last_to_cyc - last_bv_cyc) != 512) begin
      tests_failed++;
      $display("FAIL timeout_delay got count=%0d delay=%0d exp count=1 delay=512", n_to, last_to_cyc - last_bv_cyc);
    end
    tests_run++;
    if (bus.carrier_lock !== 1'b0 || dut.state_q !== SEARCH) begin
      tests_failed++;
      $display("FAIL timeout_state got lock=%b state=%0d exp lock=0 state=%0d", bus.carrier_lock, dut.state_q, SEARCH);
    end
    run(600);
    tests_run++;
    if (n_to != 1 || n_bv != 0) begin
      tests_failed++; $display("FAIL timeout_search_idle got to=%0d bv=%0d exp to=1 bv=0", n_to, n_bv);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    mode = 2;
    run(800);
    tests_run++;
    if (n_gl < 18) begin
      tests_failed++; $display("FAIL glitch_count got=%0d exp>=18", n_gl);
    end
    tests_run++;
    if (gl_ivl_min != 40 || gl_ivl_max != 40) begin
      tests_failed++; $display("FAIL glitch_interval got=%0d..%0d exp=40", gl_ivl_min, gl_ivl_max);
    end
    tests_run++;
    if (n_bv != 0 || n_lock_high != 0 || n_to != 0 || n_excl != 0) begin
      tests_failed++;
      $display("FAIL glitch_status got bv=%0d lockcyc=%0d to=%0d excl=%0d exp=0", n_bv, n_lock_high, n_to, n_excl);
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    mode = 0; step = 2; amp = 30000.0;
    run(300);
    tests_run++;
    if (bus.carrier_lock !== 1'b1) begin
      tests_failed++; $display("FAIL hyst_prelock got=%b exp=1", bus.carrier_lock);
    end
    amp = 900.0;
    clear_stats();
    run(700);
    tests_run++;
    if (n_to != 1 || n_bv != 0 || n_gl != 0) begin
      tests_failed++; $display("FAIL hyst_small got to=%0d bv=%0d gl=%0d exp to=1 bv=0 gl=0", n_to, n_bv, n_gl);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 0; step = 2; amp = 30000.0;
    run(330);
    tests_run++;
    if (bus.carrier_lock !== 1'b1 || dut.state_q !== MEASURE) begin
      tests_failed++; $display("FAIL midrst_pre got lock=%b state=%0d exp lock=1 state=1", bus.carrier_lock, dut.state_q);
    end
    #5;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.bit_out, bus.bit_valid, bus.period, bus.carrier_lock, bus.glitch, bus.timeout} !== 15'd0) begin
      tests_failed++;
      $display("FAIL midrst_async got=%b exp=0",
               {bus.bit_out, bus.bit_valid, bus.period, bus.carrier_lock, bus.glitch, bus.timeout});
    end
    repeat (2) @(posedge clk);
    #5;
    rst_n = 1'b1;
    clear_stats();
    run(128);
    tests_run++;
    if (n_bv != 0) begin
      tests_failed++; $display("FAIL midrst_first_crossing got bv=%0d exp=0", n_bv);
    end
    run(300);
    tests_run++;
    if (n_bv < 1 || per_min != 128 || per_max != 128) begin
      tests_failed++; $display("FAIL midrst_resume got bv=%0d period=%0d..%0d exp bv>=1 period=128", n_bv, per_min, per_max);
    end
  endtask

  initial begin
    bus.signal = 16'd32768;
    clear_stats();
    test_reset();
    test_fast_tone();
    test_tone_switch();
    test_timeout();
    test_glitch();
    test_hysteresis();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
